// File: rtl/ow_pkg.sv
// =============================================================================
// Module   : ow_pkg
// Brief    : Shared 1-Wire master types and default slot timing constants.
// Revision : 1.0
// =============================================================================
`default_nettype none

package ow_pkg;

    localparam int OW_SLOT_CYCLES      = 72;
    localparam int OW_RECOVERY_CYCLES  = 4;
    localparam int OW_BIT_STAGE_CYCLES = 71;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } ow_state_t;

endpackage

`default_nettype wire

// File: rtl/ow_byte_serializer_if.sv
// =============================================================================
// Module   : ow_byte_serializer_if
// Brief    : Byte valid/ready channel feeding the 1-Wire byte serializer.
// Revision : 1.0
// =============================================================================
`default_nettype none

interface ow_byte_serializer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

`default_nettype wire

// File: rtl/ow_slot_timer.sv
// =============================================================================
// Module   : ow_slot_timer
// Brief    : Loadable saturating down-counter with zero flag for slot pacing.
// Revision : 1.0
// =============================================================================
`default_nettype none

module ow_slot_timer #(
    parameter int WIDTH = 7
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    output logic                  zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ow_byte_serializer.sv
// =============================================================================
// Module   : ow_byte_serializer
// Brief    : Buffers one byte and issues LSB-first, timer-paced bit slot requests.
// Revision : 1.0
// =============================================================================
`default_nettype none

module ow_byte_serializer
    import ow_pkg::*;
#(
    parameter int SLOT_CYCLES     = OW_SLOT_CYCLES,
    parameter int RECOVERY_CYCLES = OW_RECOVERY_CYCLES,
    parameter int DATA_W          = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    ow_byte_serializer_if.slave       up,
    output logic                      bit_to_send,
    output logic                      bit_ready,
    output logic                      byte_done,
    output logic                      busy
);

    localparam int TIMER_W = $clog2(SLOT_CYCLES + RECOVERY_CYCLES);
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TIMER_W-1:0] C_TIMER_LOAD = TIMER_W'(SLOT_CYCLES + RECOVERY_CYCLES - 1);
    localparam logic [IDX_W-1:0]   C_LAST_IDX   = IDX_W'(DATA_W - 1);

    ow_state_t         r_state;
    ow_state_t         w_next_state;
    logic              r_hold_valid;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              w_timer_zero;
    logic              w_timer_load;
    logic              w_accept;
    logic              w_last_bit;
    logic              w_slot_end;
    logic              w_load_shift;

    assign w_accept   = up.in_valid && !r_hold_valid;
    assign w_last_bit = (r_bit_idx == C_LAST_IDX);
    assign w_slot_end = (r_state == ST_WAIT) && w_timer_zero;
    // Hold is drained either from idle or straight after the last slot, so
    // consecutive bytes keep the same request spacing.
    assign w_load_shift = r_hold_valid &&
                          ((r_state == ST_IDLE) || (w_slot_end && w_last_bit));

    ow_slot_timer #(
        .WIDTH (TIMER_W)
    ) u_slot_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_timer_load),
        .load_val (C_TIMER_LOAD),
        .zero     (w_timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (r_hold_valid) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_timer_zero) begin
                    if (!w_last_bit || r_hold_valid) w_next_state = ST_ISSUE;
                    else                             w_next_state = ST_IDLE;
                end
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_ready    = (r_state == ST_ISSUE);
        w_timer_load = (r_state == ST_ISSUE);
        byte_done    = w_slot_end && w_last_bit;
        busy         = (r_state != ST_IDLE) || r_hold_valid;
        bit_to_send  = r_shift[0];
        up.in_ready  = !r_hold_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
        end else begin
            if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold       <= up.in_data;
            end else if (w_load_shift) begin
                r_hold_valid <= 1'b0;
            end

            if (w_load_shift) begin
                r_shift   <= r_hold;
                r_bit_idx <= '0;
            end else if (w_slot_end && !w_last_bit) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ow_byte_serializer.sv
// =============================================================================
// Module   : tb_ow_byte_serializer
// Brief    : Directed self-checking bench for the 1-Wire byte serializer.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_ow_byte_serializer;

    localparam int FIRST_REQ = 2;
    localparam int BIT_P     = 77;
    localparam int BYTE_P    = 616;
    localparam int DONE_OFF  = 617;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_to_send, bit_ready, byte_done, busy;

    ow_byte_serializer_if #(.DATA_W(8)) bus ();

    ow_byte_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .up          (bus),
        .bit_to_send (bit_to_send),
        .bit_ready   (bit_ready),
        .byte_done   (byte_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int rq_t[$];
    bit rq_b[$];
    int dq_t[$];
    bit exp_q[$];

    always @(negedge clk) begin
        if (bit_ready) begin
            rq_t.push_back(cyc);
            rq_b.push_back(bit_to_send);
        end
        if (byte_done) dq_t.push_back(cyc);
        if (bit_ready && byte_done) overlap++;
    end

    typedef struct {
        logic [7:0] data;
        bit         exp [8];
    } vec_t;
    vec_t vecs [3];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic clear_mon();
        rq_t.delete();
        rq_b.delete();
        dq_t.delete();
        exp_q.delete();
    endtask

    task automatic wait_ready(output int acc);
        int n = 0;
        while (!bus.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", int'(bus.in_ready), 1);
        acc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] d, output int acc);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        wait_ready(acc);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < limit);
        repeat (3) @(negedge clk);
        chk("idle_wait", int'(busy), 0);
    endtask

    task automatic verify(input int acc, input int nb);
        chk("req_count", rq_t.size(), nb * 8);
        for (int i = 0; i < rq_t.size() && i < nb * 8; i++) begin
            chk($sformatf("req_time[%0d]", i), rq_t[i], acc + FIRST_REQ + BIT_P * i);
            chk($sformatf("req_bit[%0d]", i), int'(rq_b[i]), int'(exp_q[i]));
        end
        chk("done_count", dq_t.size(), nb);
        for (int k = 0; k < dq_t.size() && k < nb; k++)
            chk($sformatf("done_time[%0d]", k), dq_t[k], acc + DONE_OFF + BYTE_P * k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc0, acc1, acc2, seen, n;

        vecs[0].data = 8'hA5; vecs[0].exp = '{1, 0, 1, 0, 0, 1, 0, 1};
        vecs[1].data = 8'h3C; vecs[1].exp = '{0, 0, 1, 1, 1, 1, 0, 0};
        vecs[2].data = 8'h81; vecs[2].exp = '{1, 0, 0, 0, 0, 0, 0, 1};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset and idle
        repeat (20) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bit_ready", int'(bit_ready), 0);
        chk("rst_byte_done", int'(byte_done), 0);
        chk("rst_bit_to_send", int'(bit_to_send), 0);
        chk("idle_no_requests", rq_t.size(), 0);

        // Single bytes from idle
        for (int v = 0; v < 3; v++) begin
            clear_mon();
            for (int i = 0; i < 8; i++) exp_q.push_back(vecs[v].exp[i]);
            send_byte(vecs[v].data, acc);
            wait_idle(1000);
            verify(acc, 1);
        end

        // Back-to-back 00, FF, then 5A offered while the hold register is full
        clear_mon();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        wait_ready(acc0);
        @(negedge clk);
        chk("full_in_ready", int'(bus.in_ready), 0);
        bus.in_data = 8'hFF;
        wait_ready(acc1);
        chk("second_accept_cycle", acc1, acc0 + 2);
        @(negedge clk);
        bus.in_data = 8'h5A;
        chk("hold_full_in_ready", int'(bus.in_ready), 0);
        wait_ready(acc2);
        chk("third_accept_cycle", acc2, acc0 + 618);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_idle(3000);
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        verify(acc0, 3);

        // Asynchronous reset during bit 3 of 8'h3C, then a clean 8'h81
        clear_mon();
        send_byte(8'h3C, acc);
        seen = 0;
        n = 0;
        while (seen < 4 && n < 1000) begin
            if (bit_ready) seen++;
            if (seen < 4) begin
                @(negedge clk);
                n++;
            end
        end
        chk("bit3_reached", seen, 4);
        chk("bit3_value", int'(bit_to_send), 1);
        rst = 1'b1;
        #1;
        chk("arst_bit_ready", int'(bit_ready), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_in_ready", int'(bus.in_ready), 1);
        chk("arst_bit_to_send", int'(bit_to_send), 0);
        chk("arst_byte_done", int'(byte_done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (700) @(negedge clk);
        chk("arst_no_byte_done", dq_t.size(), 0);
        chk("arst_busy_after", int'(busy), 0);
        clear_mon();
        for (int i = 0; i < 8; i++) exp_q.push_back(vecs[2].exp[i]);
        send_byte(8'h81, acc);
        wait_idle(1000);
        verify(acc, 1);

        chk("ready_done_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
